alu_seq_ctrl: RTL and testbench

- Multi-cycle command sequencer that owns one shared combinational 32-bit ALU.
- The ALU provides AND, OR, ADD, SUB, shift-right-by-1, shift-left-by-1 and zero flag; this block drives its operands and op code.
- The block builds multi-cycle operations from it: unsigned multiply (low 32 bits, shift-and-add) and variable-distance shifts (repeated 1-bit shifts).
- It sits between the CPU execute stage (start/done handshake) and the ALU instance.

---
 rtl/alu_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle command sequencer driving one shared combinational ALU.
// Builds 32x32 low-word multiply (shift-and-add) and variable-distance shifts.
module alu_seq_ctrl #(
  parameter int unsigned MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  shamt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry,
  output logic        err
);

  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpShr1 = 3'b100;
  localparam logic [2:0] OpShl1 = 3'b101;
  localparam logic [2:0] OpZero = 3'b110;

  typedef enum logic [2:0] {StIdle, StAdd, StShl, StShr, StSh, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic [31:0] q_q, q_d;
  logic [5:0]  count_q, count_d;
  logic        shl_q, shl_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        err_q, err_d;
  logic [5:0]  cnt_inc;

  assign cnt_inc = count_q + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      count_q  <= '0;
      shl_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      q_q      <= q_d;
      count_q  <= count_d;
      shl_q    <= shl_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    m_d      = m_q;
    q_d      = q_q;
    count_d  = count_q;
    shl_d    = shl_q;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;
    alu_op   = OpZero;
    alu_a    = '0;
    alu_b    = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          carry_d = 1'b0;
          err_d   = 1'b0;
          m_d     = op_a;
          unique case (cmd)
            2'b00: begin
              acc_d   = '0;
              q_d     = op_b;
              count_d = '0;
              if (op_b == '0) begin
                result_d = '0;
                state_d  = StDone;
              end else begin
                state_d = op_b[0] ? StAdd : StShl;
              end
            end
            2'b01, 2'b10: begin
              count_d = {1'b0, shamt};
              shl_d   = (cmd == 2'b01);
              if (shamt == '0) begin
                result_d = op_a;
                state_d  = StDone;
              end else begin
                state_d = StSh;
              end
            end
            2'b11: begin
              err_d    = 1'b1;
              result_d = '0;
              state_d  = StDone;
            end
          endcase
        end
      end
      StAdd: begin
        alu_a   = acc_q;
        alu_b   = m_q;
        alu_op  = OpAdd;
        acc_d   = alu_result;
        carry_d = carry_q | alu_cout;
        state_d = StShl;
      end
      StShl: begin
        alu_a   = m_q;
        alu_op  = OpShl1;
        m_d     = alu_result;
        state_d = StShr;
      end
      StShr: begin
        alu_a   = q_q;
        alu_op  = OpShr1;
        q_d     = alu_result;
        count_d = cnt_inc;
        // Stop early once the remaining multiplier bits are all zero.
        if (alu_zero || (32'(cnt_inc) == MUL_ITERS)) begin
          result_d = acc_q;
          state_d  = StDone;
        end else begin
          state_d = alu_result[0] ? StAdd : StShl;
        end
      end
      StSh: begin
        alu_a   = m_q;
        alu_op  = shl_q ? OpShl1 : OpShr1;
        m_d     = alu_result;
        count_d = count_q - 6'd1;
        if (count_q == 6'd1) begin
          result_d = alu_result;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy   = (state_q != StIdle) && (state_q != StDone);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign carry  = carry_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl; the bench models the combinational ALU.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] alu_a, alu_b, alu_result, result;
  logic [2:0]  alu_op;
  logic        alu_cout, alu_zero, busy, done, carry, err;

  int n_cmp = 0;
  int n_bad = 0;
  int idle_bad = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.MUL_ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .op_a(op_a), .op_b(op_b),
    .shamt(shamt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_cout(alu_cout), .alu_zero(alu_zero), .busy(busy), .done(done), .result(result),
    .carry(carry), .err(err)
  );

  always_comb begin
    alu_cout   = 1'b0;
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b011: alu_result = alu_a - alu_b;
      3'b100: alu_result = alu_a >> 1;
      3'b101: alu_result = alu_a << 1;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  // Any non-busy cycle (IDLE or DONE) must present the zero op and zero operands.
  always @(negedge clk) begin
    if (mon_en && rst_n && !busy && (alu_op !== 3'b110 || alu_a !== '0 || alu_b !== '0))
      idle_bad++;
  end

  task automatic run_cmd(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, output int lat);
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    cmd = c; op_a = a; op_b = b; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
    if (carry !== 1'b0) begin n_bad++; $display("FAIL reset_carry got %b want 0", carry); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    if (alu_op !== 3'b110) begin n_bad++; $display("FAIL reset_aluop got %b want 110", alu_op); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_mul_3x5();
    logic [2:0] exp_ops [8] = '{3'b010, 3'b101, 3'b100, 3'b101, 3'b100, 3'b010, 3'b101, 3'b100};
    @(negedge clk);
    cmd = 2'b00; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (alu_op !== exp_ops[i]) begin
        n_bad++;
        $display("FAIL mul3x5_op[%0d] got %b want %b", i, alu_op, exp_ops[i]);
      end
      @(posedge clk); #1;
    end
    n_cmp += 5;
    if (done !== 1'b1) begin n_bad++; $display("FAIL mul3x5_done got %b want 1", done); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mul3x5_busy got %b want 0", busy); end
    if (result !== 32'd15) begin n_bad++; $display("FAIL mul3x5_result got %0d want 15", result); end
    if (carry !== 1'b0) begin n_bad++; $display("FAIL mul3x5_carry got %b want 0", carry); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL mul3x5_err got %b want 0", err); end
    @(posedge clk); #1;
    n_cmp += 2;
    if (done !== 1'b0) begin n_bad++; $display("FAIL mul3x5_pulse got %b want 0", done); end
    if (result !== 32'd15) begin n_bad++; $display("FAIL mul3x5_hold got %0d want 15", result); end
  endtask

  task automatic test_reset_mid_mul();
    logic [2:0] exp_ops [4] = '{3'b010, 3'b101, 3'b100, 3'b101};
    logic seen = 1'b0;
    int lat;
    @(negedge clk);
    cmd = 2'b00; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (alu_op !== exp_ops[i]) begin
        n_bad++;
        $display("FAIL rstmid_op[%0d] got %b want %b", i, alu_op, exp_ops[i]);
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (result !== 32'h0) begin n_bad++; $display("FAIL rstmid_result got %h want 0", result); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_nodone got %b want 0", seen); end
    run_cmd(2'b00, 32'd6, 32'd7, 5'd0, lat);
    n_cmp += 2;
    if (lat != 9) begin n_bad++; $display("FAIL rstmid_next_lat got %0d want 9", lat); end
    if (result !== 32'd42) begin n_bad++; $display("FAIL rstmid_next_res got %0d want 42", result); end
  endtask

  task automatic test_mul_max();
    int lat;
    run_cmd(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, lat);
    n_cmp += 4;
    if (lat != 96) begin n_bad++; $display("FAIL mulmax_lat got %0d want 96", lat); end
    if (result !== 32'h1) begin n_bad++; $display("FAIL mulmax_result got %h want 1", result); end
    if (carry !== 1'b1) begin n_bad++; $display("FAIL mulmax_carry got %b want 1", carry); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL mulmax_err got %b want 0", err); end
  endtask

  task automatic test_mul_zero_and_ignore();
    int lat;
    run_cmd(2'b00, 32'd123, 32'd0, 5'd0, lat);
    n_cmp += 2;
    if (lat != 0) begin n_bad++; $display("FAIL mulzero_lat got %0d want 0", lat); end
    if (result !== 32'h0) begin n_bad++; $display("FAIL mulzero_result got %h want 0", result); end
    @(negedge clk);
    @(negedge clk);
    cmd = 2'b00; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin
      if (lat == 2) begin
        cmd = 2'b01; op_a = 32'hDEAD_BEEF; op_b = 32'd9; shamt = 5'd3; start = 1'b1;
      end
      if (lat == 5) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_cmp += 2;
    if (lat != 8) begin n_bad++; $display("FAIL ignore_lat got %0d want 8", lat); end
    if (result !== 32'd15) begin n_bad++; $display("FAIL ignore_result got %0d want 15", result); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_noqueue got %b want 0", busy); end
  endtask

  task automatic test_shifts();
    int lat;
    run_cmd(2'b01, 32'h8000_0001, 32'd0, 5'd4, lat);
    n_cmp += 3;
    if (lat != 4) begin n_bad++; $display("FAIL shl4_lat got %0d want 4", lat); end
    if (result !== 32'h10) begin n_bad++; $display("FAIL shl4_result got %h want 10", result); end
    if (carry !== 1'b0) begin n_bad++; $display("FAIL shl4_carry got %b want 0", carry); end
    run_cmd(2'b10, 32'h8000_0000, 32'd0, 5'd31, lat);
    n_cmp += 2;
    if (lat != 31) begin n_bad++; $display("FAIL shr31_lat got %0d want 31", lat); end
    if (result !== 32'h1) begin n_bad++; $display("FAIL shr31_result got %h want 1", result); end
    run_cmd(2'b01, 32'h1234_5678, 32'd0, 5'd0, lat);
    n_cmp += 2;
    if (lat != 0) begin n_bad++; $display("FAIL shl0_lat got %0d want 0", lat); end
    if (result !== 32'h1234_5678) begin
      n_bad++; $display("FAIL shl0_result got %h want 12345678", result);
    end
    run_cmd(2'b10, 32'h0000_00F0, 32'd0, 5'd3, lat);
    n_cmp += 2;
    if (lat != 3) begin n_bad++; $display("FAIL shr3_lat got %0d want 3", lat); end
    if (result !== 32'h1E) begin n_bad++; $display("FAIL shr3_result got %h want 1e", result); end
  endtask

  task automatic test_illegal();
    int lat;
    run_cmd(2'b11, 32'd5, 32'd7, 5'd2, lat);
    n_cmp += 3;
    if (lat != 0) begin n_bad++; $display("FAIL illegal_lat got %0d want 0", lat); end
    if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err got %b want 1", err); end
    if (result !== 32'h0) begin n_bad++; $display("FAIL illegal_result got %h want 0", result); end
    run_cmd(2'b00, 32'd10, 32'd2, 5'd0, lat);
    n_cmp += 2;
    if (err !== 1'b0) begin n_bad++; $display("FAIL illegal_clear_err got %b want 0", err); end
    if (result !== 32'd20) begin n_bad++; $display("FAIL after_illegal_res got %0d want 20", result); end
  endtask

  task automatic test_idle_drive();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (idle_bad != 0) begin n_bad++; $display("FAIL idle_drive got %0d bad cycles want 0", idle_bad); end
  endtask

  initial begin
    test_reset();
    test_mul_3x5();
    test_reset_mid_mul();
    test_mul_max();
    test_mul_zero_and_ignore();
    test_shifts();
    test_illegal();
    test_idle_drive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
